// File: rtl/wb_master_engine.sv
// Wishbone classic-cycle initiator: expands a burst command into single-beat
// transfers, with streamed write data, streamed read data and an ack timeout.
module wb_master_engine #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [7:0]  cmd_len,
    input  logic        wdat_valid,
    output logic        wdat_ready,
    input  logic [31:0] wdat_data,
    output logic        rdat_valid,
    input  logic        rdat_ready,
    output logic [31:0] rdat_data,
    output logic        done_o,
    output logic        err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int unsigned TMO_W    = 16;
    localparam int unsigned ADR_STEP = 4;
    localparam bit               TMO_EN   = (TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDAT,
        ST_BUS,
        ST_RSP
    } state_t;

    state_t           state;
    logic [7:0]       beat_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             last_beat;
    logic             tmo_hit;

    assign cmd_ready = (state == ST_IDLE);
    assign last_beat = (beat_cnt == 8'd0);
    // tmo_cnt holds the number of completed strobe cycles before the current one
    assign tmo_hit   = TMO_EN && (tmo_cnt == TMO_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            beat_cnt   <= 8'd0;
            tmo_cnt    <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= 4'd0;
            wbm_adr_o  <= 32'd0;
            wbm_dat_o  <= 32'd0;
            wdat_ready <= 1'b0;
            rdat_valid <= 1'b0;
            rdat_data  <= 32'd0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= {cmd_adr[31:2], 2'b00};
                        wbm_sel_o <= cmd_sel;
                        beat_cnt  <= cmd_len;
                        wbm_cyc_o <= 1'b1;
                        if (cmd_we) begin
                            wdat_ready <= 1'b1;
                            state      <= ST_WDAT;
                        end else begin
                            wbm_stb_o <= 1'b1;
                            tmo_cnt   <= '0;
                            state     <= ST_BUS;
                        end
                    end
                end
                ST_WDAT: begin
                    if (wdat_valid) begin
                        wbm_dat_o  <= wdat_data;
                        wdat_ready <= 1'b0;
                        wbm_stb_o  <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wbm_ack_i) begin
                        wbm_stb_o <= 1'b0;
                        if (!wbm_we_o) begin
                            rdat_data  <= wbm_dat_i;
                            rdat_valid <= 1'b1;
                            state      <= ST_RSP;
                        end else if (last_beat) begin
                            wbm_cyc_o <= 1'b0;
                            done_o    <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            wbm_adr_o  <= wbm_adr_o + 32'(ADR_STEP);
                            beat_cnt   <= beat_cnt - 8'd1;
                            wdat_ready <= 1'b1;
                            state      <= ST_WDAT;
                        end
                    end else if (tmo_hit) begin
                        // abandon the rest of the burst; unissued write data stays upstream
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        done_o    <= 1'b1;
                        err_o     <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_RSP: begin
                    if (rdat_ready) begin
                        rdat_valid <= 1'b0;
                        if (last_beat) begin
                            wbm_cyc_o <= 1'b0;
                            done_o    <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            wbm_adr_o <= wbm_adr_o + 32'(ADR_STEP);
                            beat_cnt  <= beat_cnt - 8'd1;
                            wbm_stb_o <= 1'b1;
                            tmo_cnt   <= '0;
                            state     <= ST_BUS;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_engine.sv
// Randomised bench for wb_master_engine: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_master_engine;

    localparam int unsigned TMO = 8;

    logic        wb_clk_i, wb_rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [7:0]  cmd_len;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat_data;
    logic        rdat_valid, rdat_ready;
    logic [31:0] rdat_data;
    logic        done_o, err_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    wb_master_engine #(.TIMEOUT(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data),
        .done_o(done_o), .err_o(err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct { logic we; logic [31:0] adr; logic [3:0] sel; logic [7:0] len; } cmd_t;
    typedef struct { logic we; logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; } xfer_t;

    cmd_t        cq[$];
    logic [31:0] wq[$];
    xfer_t       obs[$];
    logic [31:0] rd_obs[$];

    int n_checks = 0, n_errors = 0;
    int cyc_n = 0;

    // stimulus configuration
    bit gaps = 0, slv_never = 0, stray_en = 0;
    int rdy_mode = 0, slv_wait = 0, hold = 0, swcnt = 0, swtarget = 0;
    bit hs_cmd = 0, hs_wdat = 0, hs_rdat = 0;

    // reference model: one outstanding burst, tracked per beat
    bit          busy = 0, m_we = 0, m_dt = 0, m_rp = 0, exp_done = 0, exp_err = 0;
    logic [31:0] m_base = 0, m_wdat = 0, m_rdat = 0;
    logic [3:0]  m_sel = 0;
    int          m_len = 0, m_beat = 0, m_stbcnt = 0;
    int          stb_seen = 0, obs_done = 0, obs_err = 0, cmd_cycle = 0, done_cycle = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h3000_0000) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [7:0] len);
        cmd_t c;
        c.we = we; c.adr = adr; c.sel = sel; c.len = len;
        cq.push_back(c);
    endtask

    task automatic m_finish(input bit e);
        busy = 0; m_dt = 0; m_rp = 0;
        exp_done = 1; exp_err = e;
    endtask

    task automatic m_next_beat();
        if (m_beat == m_len) m_finish(1'b0);
        else begin
            m_beat++;
            m_stbcnt = 0;
        end
    endtask

    // drive all inputs just after the rising edge
    task automatic drive();
        @(posedge wb_clk_i);
        cyc_n++;
        #1;
        if (hs_cmd)  cq.delete(0);
        if (hs_wdat) wq.delete(0);
        if (hs_rdat) hold = 0;
        if (!(cmd_valid && !hs_cmd)) begin
            if (cq.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                cmd_valid = 1'b1; cmd_we = cq[0].we; cmd_adr = cq[0].adr;
                cmd_sel = cq[0].sel; cmd_len = cq[0].len;
            end else begin
                cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = $urandom;
                cmd_sel = 4'($urandom); cmd_len = 8'($urandom);
            end
        end
        if (!(wdat_valid && !hs_wdat)) begin
            if (wq.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                wdat_valid = 1'b1; wdat_data = wq[0];
            end else begin
                wdat_valid = 1'b0; wdat_data = $urandom;
            end
        end
        case (rdy_mode)
            0: rdat_ready = 1'b1;
            1: rdat_ready = 1'($urandom_range(0, 1));
            default: begin
                if (rdat_valid && hold < 5) begin
                    rdat_ready = 1'b0;
                    hold++;
                end else rdat_ready = 1'b1;
            end
        endcase
        if (wbm_stb_o && wbm_cyc_o) begin
            if (slv_never) begin
                wbm_ack_i = 1'b0; wbm_dat_i = $urandom;
            end else if (swcnt >= swtarget) begin
                wbm_ack_i = 1'b1; wbm_dat_i = rd_word(wbm_adr_o);
            end else begin
                wbm_ack_i = 1'b0; wbm_dat_i = $urandom; swcnt++;
            end
        end else begin
            swcnt = 0;
            swtarget = (slv_wait < 0) ? int'($urandom_range(0, 3)) : slv_wait;
            wbm_ack_i = stray_en && ($urandom_range(0, 3) == 0);
            wbm_dat_i = $urandom;
        end
    endtask

    // mid-cycle: check outputs against the model, then advance the model
    task automatic compare();
        bit          exp_stb;
        logic [31:0] addr;
        hs_cmd  = cmd_valid && cmd_ready && !wb_rst_i;
        hs_wdat = wdat_valid && wdat_ready && !wb_rst_i;
        hs_rdat = rdat_valid && rdat_ready && !wb_rst_i;
        if (wb_rst_i) begin
            busy = 0; m_dt = 0; m_rp = 0; exp_done = 0; exp_err = 0;
            return;
        end
        if (wbm_stb_o) stb_seen++;
        if (done_o) begin
            done_cycle = cyc_n;
            obs_done++;
            if (err_o) obs_err++;
        end
        exp_stb = busy && (m_we ? m_dt : !m_rp);
        addr = m_base + 32'(4 * m_beat);
        chk("done_o",     32'(done_o),     32'(exp_done));
        chk("err_o",      32'(err_o),      32'(exp_err));
        chk("cmd_ready",  32'(cmd_ready),  32'(!busy));
        chk("wbm_cyc_o",  32'(wbm_cyc_o),  32'(busy));
        chk("wbm_stb_o",  32'(wbm_stb_o),  32'(exp_stb));
        chk("wdat_ready", 32'(wdat_ready), 32'(busy && m_we && !m_dt));
        chk("rdat_valid", 32'(rdat_valid), 32'(busy && !m_we && m_rp));
        if (exp_stb) begin
            chk("wbm_adr_o", wbm_adr_o, addr);
            chk("wbm_sel_o", 32'(wbm_sel_o), 32'(m_sel));
            chk("wbm_we_o",  32'(wbm_we_o),  32'(m_we));
            if (m_we) chk("wbm_dat_o", wbm_dat_o, m_wdat);
        end
        if (busy && !m_we && m_rp) chk("rdat_data", rdat_data, m_rdat);

        exp_done = 0; exp_err = 0;
        if (!busy) begin
            if (cmd_valid) begin
                busy = 1; m_we = cmd_we; m_base = {cmd_adr[31:2], 2'b00};
                m_sel = cmd_sel; m_len = int'(cmd_len); m_beat = 0;
                m_dt = 0; m_rp = 0; m_stbcnt = 0; cmd_cycle = cyc_n;
            end
        end else if (m_we && !m_dt) begin
            if (wdat_valid) begin
                m_dt = 1; m_wdat = wdat_data; m_stbcnt = 0;
            end
        end else if (exp_stb) begin
            if (wbm_ack_i) begin
                obs.push_back('{we: wbm_we_o, adr: wbm_adr_o, sel: wbm_sel_o, dat: wbm_dat_o});
                if (m_we) begin
                    m_dt = 0;
                    m_next_beat();
                end else begin
                    m_rp = 1;
                    m_rdat = rd_word(addr);
                end
            end else begin
                m_stbcnt++;
                if (m_stbcnt == int'(TMO)) m_finish(1'b1);
            end
        end else if (rdat_ready) begin
            rd_obs.push_back(rdat_data);
            m_rp = 0;
            m_next_beat();
        end
    endtask

    task automatic step();
        drive();
        @(negedge wb_clk_i);
        compare();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int b;
        b = budget;
        step();
        while ((cq.size() > 0 || busy || cmd_valid) && b > 0) begin
            step();
            b--;
        end
        chk({name, "_idle"}, 32'(busy || cq.size() > 0), 32'd0);
        step();
        step();
    endtask

    int d0, e0, o0, r0, s0, k;

    initial begin
        wb_rst_i = 1'b1;
        cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_sel = 0; cmd_len = 0;
        wdat_valid = 0; wdat_data = 0; rdat_ready = 0; wbm_ack_i = 0; wbm_dat_i = 0;
        step();
        step();
        chk("rst_cyc", 32'(wbm_cyc_o), 0);
        chk("rst_stb", 32'(wbm_stb_o), 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_rdat_valid", 32'(rdat_valid), 0);
        #1 wb_rst_i = 1'b0;
        step();
        chk("rel_cmd_ready", 32'(cmd_ready), 1);

        // single read, zero-wait slave
        slv_wait = 0; rdy_mode = 0;
        d0 = obs_done; e0 = obs_err; r0 = rd_obs.size();
        push_cmd(1'b0, 32'h3000_0000, 4'hF, 8'd0);
        run_until_idle("t1", 50);
        chk("t1_nread", rd_obs.size() - r0, 1);
        if (rd_obs.size() > r0) chk("t1_rdata", rd_obs[r0], 32'hDEAD_BEEF);
        chk("t1_latency", done_cycle - cmd_cycle, 3);
        chk("t1_done", obs_done - d0, 1);
        chk("t1_err", obs_err - e0, 0);

        // write burst, two wait states per beat
        slv_wait = 2;
        d0 = obs_done; o0 = obs.size();
        for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
        push_cmd(1'b1, 32'h3000_0010, 4'b0110, 8'd3);
        run_until_idle("t2", 100);
        chk("t2_beats", obs.size() - o0, 4);
        if (obs.size() >= o0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_adr", obs[o0+i].adr, 32'h3000_0010 + 32'(4 * i));
                chk("t2_dat", obs[o0+i].dat, 32'(i + 1));
                chk("t2_sel", 32'(obs[o0+i].sel), 32'h6);
            end
        end
        chk("t2_latency", done_cycle - cmd_cycle, 17);
        chk("t2_done", obs_done - d0, 1);

        // read with 5-cycle backpressure on each beat
        slv_wait = 0; rdy_mode = 2; hold = 0;
        o0 = obs.size(); r0 = rd_obs.size();
        push_cmd(1'b0, 32'h3000_0000, 4'hA, 8'd1);
        run_until_idle("t3", 100);
        chk("t3_nread", rd_obs.size() - r0, 2);
        if (rd_obs.size() > r0) chk("t3_rdata0", rd_obs[r0], 32'hDEAD_BEEF);
        if (obs.size() >= o0 + 2) chk("t3_adr1", obs[o0+1].adr, 32'h3000_0004);
        chk("t3_latency", done_cycle - cmd_cycle, 15);

        // timeout on a write, then recovery
        rdy_mode = 0; slv_never = 1;
        d0 = obs_done; e0 = obs_err; s0 = stb_seen;
        for (int i = 0; i < 3; i++) wq.push_back(32'hC0DE_0000 + 32'(i));
        push_cmd(1'b1, 32'h3000_0100, 4'hF, 8'd2);
        run_until_idle("t4", 100);
        chk("t4_stb_cycles", stb_seen - s0, 8);
        chk("t4_done", obs_done - d0, 1);
        chk("t4_err", obs_err - e0, 1);
        chk("t4_wdat_left", wq.size(), 2);
        wq.delete();
        wdat_valid = 1'b0;
        slv_never = 0;
        d0 = obs_done; e0 = obs_err;
        push_cmd(1'b0, 32'h3000_0000, 4'hF, 8'd0);
        run_until_idle("t4b", 50);
        chk("t4b_done", obs_done - d0, 1);
        chk("t4b_err", obs_err - e0, 0);

        // address wrap
        slv_wait = 1; o0 = obs.size();
        push_cmd(1'b0, 32'hFFFF_FFFE, 4'hF, 8'd1);
        run_until_idle("t5", 50);
        chk("t5_beats", obs.size() - o0, 2);
        if (obs.size() >= o0 + 2) begin
            chk("t5_adr0", obs[o0].adr, 32'hFFFF_FFFC);
            chk("t5_adr1", obs[o0+1].adr, 32'h0000_0000);
        end

        // randomised traffic
        gaps = 1; rdy_mode = 1; slv_wait = -1; stray_en = 1;
        d0 = obs_done; e0 = obs_err;
        for (int i = 0; i < 40; i++) begin
            logic       w;
            logic [7:0] l;
            w = 1'($urandom);
            l = 8'($urandom_range(0, 5));
            push_cmd(w, $urandom, 4'($urandom), l);
            if (w) for (int j = 0; j <= int'(l); j++) wq.push_back($urandom);
        end
        run_until_idle("t6", 8000);
        chk("t6_done", obs_done - d0, 40);
        chk("t6_err", obs_err - e0, 0);

        // asynchronous reset mid-write while strobe is high
        gaps = 0; rdy_mode = 0; slv_wait = 3; stray_en = 0;
        for (int i = 0; i < 4; i++) wq.push_back(32'hA5A5_0001 + 32'(i));
        push_cmd(1'b1, 32'h3000_0200, 4'h3, 8'd3);
        k = 0;
        step();
        while (!wbm_stb_o && k < 20) begin
            step();
            k++;
        end
        chk("t7_stb_before_rst", 32'(wbm_stb_o), 1);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("t7_cyc", 32'(wbm_cyc_o), 0);
        chk("t7_stb", 32'(wbm_stb_o), 0);
        chk("t7_we", 32'(wbm_we_o), 0);
        chk("t7_sel", 32'(wbm_sel_o), 0);
        chk("t7_adr", wbm_adr_o, 0);
        chk("t7_dat", wbm_dat_o, 0);
        chk("t7_rdat_valid", 32'(rdat_valid), 0);
        chk("t7_rdat_data", rdat_data, 0);
        chk("t7_wdat_ready", 32'(wdat_ready), 0);
        chk("t7_done", 32'(done_o), 0);
        chk("t7_err", 32'(err_o), 0);
        cq.delete(); wq.delete();
        cmd_valid = 1'b0; wdat_valid = 1'b0;
        hs_cmd = 0; hs_wdat = 0; hs_rdat = 0;
        d0 = obs_done;
        step();
        step();
        #1 wb_rst_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t7_cmd_ready", 32'(cmd_ready), 1);
        chk("t7_no_done", obs_done - d0, 0);
        push_cmd(1'b0, 32'h3000_0000, 4'hF, 8'd0);
        run_until_idle("t7b", 50);
        chk("t7b_done", obs_done - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_master_engine.md
# wb_master_engine

Wishbone classic-cycle initiator that turns a command (address, byte select, beat count, direction) into one or more single-beat Wishbone transfers on a master port. It sits upstream of the user project wrapper's Wishbone slave port, so a test harness or on-chip sequencer can drive that port. Write data arrives on a valid/ready stream, and read data leaves on a valid/ready stream. A per-beat ack timeout guards against a slave that never responds.

## Interface
- TIMEOUT, 255: cycles with stb high and no ack before the engine aborts; 0 disables the timeout.
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_adr  in  32  start byte address; bits [1:0] are ignored and forced to 0.
- cmd_sel  in  4  byte select applied to every beat.
- cmd_len  in  8  beats minus 1 (0..255 gives 1..256 beats).
- wdat_valid / wdat_ready  in / out  1  write-data handshake.
- wdat_data  in  32  write-data word.
- rdat_valid / rdat_ready  out / in  1  read-data handshake.
- rdat_data  out  32  captured read word.
- done_o  out  1  one-cycle pulse when a command completes or aborts.
- err_o  out  1  qualified by done_o; 1 = timeout abort.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle, strobe and write enable.
- wbm_sel_o  out  4  Wishbone byte select.
- wbm_adr_o, wbm_dat_o  out  32  Wishbone address and write data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  32  Wishbone read data.

## Operation
- States: IDLE, WDAT, BUS, RSP.
- cmd_ready = (state == IDLE), combinational.
- IDLE:
  - On a command handshake, latch we/adr/sel/len, set beat counter = cmd_len, and raise wbm_cyc_o.
  - A write goes to WDAT; a read goes to BUS.
- WDAT:
  - wdat_ready = 1.
  - On a handshake, register wdat_data into wbm_dat_o and go to BUS.
- BUS:
  - wbm_stb_o = 1; wbm_we_o, wbm_sel_o and wbm_adr_o are driven from the latched values.
  - On wbm_ack_i, drop stb at that edge.
  - Read: capture wbm_dat_i into rdat_data, set rdat_valid, go to RSP.
  - Write, not last beat: address += 4, counter -= 1, go to WDAT.
  - Write, last beat: go to IDLE.
- RSP:
  - Hold rdat_valid/rdat_data until rdat_ready.
  - On that handshake, if not last beat: address += 4, counter -= 1, go to BUS.
  - If last beat: go to IDLE.
- wbm_cyc_o stays high for the whole burst, including WDAT/RSP stalls.
- Completion: wbm_cyc_o drops on entry to IDLE and done_o pulses in the same cycle.
- Ack received while stb is low is ignored.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Timeout:
  - A 16-bit counter clears on each stb rising and counts the cycles stb is high without ack.
  - When it reaches TIMEOUT, the next edge drops cyc and stb, discards the remaining beats, enters IDLE, and pulses done_o with err_o = 1.
  - Write data for unissued beats is not consumed.
- Reset values (all outputs): cyc/stb/we = 0, sel = 0, adr = 0, wbm_dat_o = 0, rdat_valid = 0, rdat_data = 0, wdat_ready = 0, done_o = 0, err_o = 0.
  - cmd_ready = 1 once reset is released.
  - Reset mid-burst forces these values immediately (async); no done_o is produced.

## Timing
- Read, zero-wait slave:
  - Command handshake at edge N.
  - stb high in cycle N+1, ack in the same cycle.
  - rdat_valid from N+2.
  - If rdat_ready = 1 in N+2 on the last beat, cyc drops and done_o pulses in N+3.
- Write, zero-wait slave, data ready:
  - Command at edge N; wdat handshake in N+1.
  - stb in N+2 with ack.
  - If last beat, cyc low and done_o in N+3.
- Throughput: at best one beat per 2 cycles (strobe cycle plus the WDAT/RSP cycle).
- Wishbone outputs are registered and stable while stb is high.
- err_o is valid only when done_o = 1 and is 0 otherwise.

## Test plan
- Single read:
  - Stimulus: adr 0x3000_0000, len 0, slave acks in the first cycle with 0xDEAD_BEEF.
  - Response: rdat_data = 0xDEAD_BEEF; done_o = 1, err_o = 0 exactly 3 cycles after the command.
- Write burst:
  - Stimulus: len 3, adr 0x3000_0010, data 1..4, slave inserts 2 wait states per beat.
  - Response: addresses 0x10/0x14/0x18/0x1C with data 1..4 and sel preserved; cyc continuous; done_o once.
- Read backpressure:
  - Stimulus: len 1, rdat_ready held low for 5 cycles.
  - Response: rdat_data stable; stb stays low; second beat issued only after the handshake.
- Timeout:
  - Stimulus: TIMEOUT = 8, slave never acks.
  - Response: stb high exactly 8 cycles, then cyc/stb = 0 and done_o = err_o = 1; the next command is accepted.
- Address wrap:
  - Stimulus: adr 0xFFFF_FFFC, len 1, read.
  - Response: second beat address = 0x0000_0000.
- Async reset:
  - Stimulus: assert wb_rst_i mid-write while stb is high.
  - Response: all outputs go to their reset values before the next clock edge; no done_o; cmd_ready = 1 after release.
